el2_dec_gpr_wb_queue: RTL and testbench



---
 rtl/el2_pkg.sv | 13 +
 rtl/el2_dec_gpr_wb_fifo.sv | 59 +++++
 rtl/el2_dec_gpr_wb_queue.sv | 97 +++++++++
 tb/tb_el2_dec_gpr_wb_queue.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/el2_pkg.sv
// Shared definitions for the decode-stage GPR writeback queue.
//   EL2_GPR_AW        : GPR address width
//   el2_gpr_wb_pkt_t  : one queued writeback {rd, data}
package el2_pkg;

    localparam int EL2_GPR_AW = 5;

    typedef struct packed {
        logic [EL2_GPR_AW-1:0] rd;
        logic [31:0]           data;
    } el2_gpr_wb_pkt_t;

endpackage : el2_pkg

// File: rtl/el2_dec_gpr_wb_fifo.sv
// Circular FIFO of writeback packets.
//   clk, rst_l : clock, async active-low reset
//   push, din  : enqueue request and packet (ignored while full)
//   pop        : dequeue request (ignored while empty)
//   dout       : head packet, valid only when empty=0
//   full/empty : occupancy status
module el2_dec_gpr_wb_fifo
    import el2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_l,
    input  logic            push,
    input  el2_gpr_wb_pkt_t din,
    input  logic            pop,
    output el2_gpr_wb_pkt_t dout,
    output logic            full,
    output logic            empty
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit tells full from empty once the pointers wrap.
    logic [AW:0]     wptr_q, wptr_d;
    logic [AW:0]     rptr_q, rptr_d;
    el2_gpr_wb_pkt_t mem_q [DEPTH];
    el2_gpr_wb_pkt_t mem_d [DEPTH];

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign dout  = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push && !full) begin
            mem_d[wptr_q[AW-1:0]] = din;
            wptr_d                = wptr_q + (AW+1)'(1);
        end
        if (pop && !empty) begin
            rptr_d = rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            mem_q  <= mem_d;
        end
    end

endmodule : el2_dec_gpr_wb_fifo

// File: rtl/el2_dec_gpr_wb_queue.sv
// Writeback buffer + scoreboard feeding the GPR file's second write port.
// Out-of-order load/div results are queued and drained one per cycle when
// the primary pipe is not using the port; pending destinations are tracked
// so decode can stall dependent readers.
//   issue_v/issue_rd   : op with destination dispatched (marks rd pending)
//   cancel_v/cancel_rd : op killed, rd will never return
//   ret_v/rd/data      : returning result; ret_ready = queue not full
//   port_busy          : primary writeback owns the port this cycle
//   wen/waddr/wd       : GPR write port (zeros when idle)
//   raddr0/1, rs0/1_busy : decode source lookups
//   q_empty, q_full    : queue status
module el2_dec_gpr_wb_queue
    import el2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_l,
    input  logic                  issue_v,
    input  logic [EL2_GPR_AW-1:0] issue_rd,
    input  logic                  cancel_v,
    input  logic [EL2_GPR_AW-1:0] cancel_rd,
    input  logic                  ret_v,
    input  logic [EL2_GPR_AW-1:0] ret_rd,
    input  logic [31:0]           ret_data,
    output logic                  ret_ready,
    input  logic                  port_busy,
    output logic                  wen,
    output logic [EL2_GPR_AW-1:0] waddr,
    output logic [31:0]           wd,
    input  logic [EL2_GPR_AW-1:0] raddr0,
    input  logic [EL2_GPR_AW-1:0] raddr1,
    output logic                  rs0_busy,
    output logic                  rs1_busy,
    output logic                  q_empty,
    output logic                  q_full
);

    el2_gpr_wb_pkt_t push_pkt;
    el2_gpr_wb_pkt_t head_pkt;
    logic            push;
    logic [31:0]     pending_q, pending_d;

    // ret_ready ignores a same-cycle pop so it is a pure flop-derived signal.
    assign ret_ready = ~q_full;
    // x0 results are acknowledged but never stored.
    assign push      = ret_v & ret_ready & (ret_rd != '0);
    assign push_pkt  = '{rd: ret_rd, data: ret_data};

    el2_dec_gpr_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_l (rst_l),
        .push  (push),
        .din   (push_pkt),
        .pop   (wen),
        .dout  (head_pkt),
        .full  (q_full),
        .empty (q_empty)
    );

    // Head drives the port directly; the popping write is that same cycle.
    assign wen   = ~q_empty & ~port_busy;
    assign waddr = wen ? head_pkt.rd   : '0;
    assign wd    = wen ? head_pkt.data : '0;

    // Clears applied before the set so a re-issue wins over a same-cycle clear.
    always_comb begin
        pending_d = pending_q;
        if (wen)      pending_d[head_pkt.rd] = 1'b0;
        if (cancel_v) pending_d[cancel_rd]   = 1'b0;
        if (issue_v)  pending_d[issue_rd]    = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) pending_q <= '0;
        else        pending_q <= pending_d;
    end

    // Registered view only: a pop does not bypass into the busy lookup.
    assign rs0_busy = (raddr0 != '0) & pending_q[raddr0];
    assign rs1_busy = (raddr1 != '0) & pending_q[raddr1];

`ifdef RV_ASSERT_ON
    // A kill and re-issue of the same rd in one cycle is a legal reuse.
    a_issue_pending : assert property (@(posedge clk) disable iff (!rst_l)
        !(issue_v && issue_rd != '0 && pending_q[issue_rd] &&
          !(cancel_v && cancel_rd == issue_rd)));
    a_ret_not_pending : assert property (@(posedge clk) disable iff (!rst_l)
        !(ret_v && ret_rd != '0 && !pending_q[ret_rd]));
    a_cancel_not_pending : assert property (@(posedge clk) disable iff (!rst_l)
        !(cancel_v && cancel_rd != '0 && !pending_q[cancel_rd]));
    a_ret_when_full : assert property (@(posedge clk) disable iff (!rst_l)
        !(ret_v && q_full));
`endif

endmodule : el2_dec_gpr_wb_queue

// File: tb/tb_el2_dec_gpr_wb_queue.sv
module tb_el2_dec_gpr_wb_queue;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        issue_v, cancel_v, ret_v, port_busy;
    logic [4:0]  issue_rd, cancel_rd, ret_rd, raddr0, raddr1;
    logic [31:0] ret_data;
    logic        ret_ready, wen, rs0_busy, rs1_busy, q_empty, q_full;
    logic [4:0]  waddr;
    logic [31:0] wd;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    el2_dec_gpr_wb_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst_l(rst_l),
        .issue_v(issue_v), .issue_rd(issue_rd),
        .cancel_v(cancel_v), .cancel_rd(cancel_rd),
        .ret_v(ret_v), .ret_rd(ret_rd), .ret_data(ret_data), .ret_ready(ret_ready),
        .port_busy(port_busy),
        .wen(wen), .waddr(waddr), .wd(wd),
        .raddr0(raddr0), .raddr1(raddr1),
        .rs0_busy(rs0_busy), .rs1_busy(rs1_busy),
        .q_empty(q_empty), .q_full(q_full)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; checks happen 1ns after that.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_v = 0; cancel_v = 0; ret_v = 0;
        issue_rd = 0; cancel_rd = 0; ret_rd = 0; ret_data = 0;
    endtask

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_l = 0; port_busy = 0; raddr0 = 0; raddr1 = 0;
        idle();
        #12;
        chk("rst_wen", wen, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wd", wd, 0);
        chk("rst_ready", ret_ready, 1);
        chk("rst_empty", q_empty, 1);
        chk("rst_full", q_full, 0);
        chk("rst_busy0", rs0_busy, 0);
        rst_l = 1;
        tick();

        // ---- single issue / return / write
        raddr0 = 5;
        issue_v = 1; issue_rd = 5; #1;
        chk("t1_busy_issue_cycle", rs0_busy, 0);
        tick(); idle(); #1;
        chk("t1_busy_after_issue", rs0_busy, 1);
        ret_v = 1; ret_rd = 5; ret_data = 32'hDEADBEEF; #1;
        chk("t1_no_bypass", wen, 0);
        tick(); idle(); #1;
        chk("t1_wen", wen, 1);
        chk("t1_waddr", waddr, 5);
        chk("t1_wd", wd, 32'hDEADBEEF);
        chk("t1_busy_pop_cycle", rs0_busy, 1);
        tick(); #1;
        chk("t1_wen_after", wen, 0);
        chk("t1_busy_cleared", rs0_busy, 0);
        chk("t1_empty", q_empty, 1);

        // ---- fill to full behind a busy port, then drain in order
        port_busy = 1; raddr1 = 3;
        for (int i = 1; i <= 4; i++) begin
            issue_v = 1; issue_rd = 5'(i); tick();
        end
        idle();
        for (int i = 1; i <= 4; i++) begin
            ret_v = 1; ret_rd = 5'(i); ret_data = 32'h100 + i; tick();
        end
        idle(); #1;
        chk("t2_full", q_full, 1);
        chk("t2_ready", ret_ready, 0);
        chk("t2_wen_busy", wen, 0);
        chk("t2_rs1_busy", rs1_busy, 1);
        port_busy = 0; #1;
        for (int i = 1; i <= 4; i++) begin
            chk("t2_drain_wen", wen, 1);
            chk("t2_drain_waddr", waddr, i);
            chk("t2_drain_wd", wd, 32'h100 + i);
            tick(); #1;
        end
        chk("t2_empty", q_empty, 1);
        chk("t2_wen_idle", wen, 0);
        chk("t2_rs1_clear", rs1_busy, 0);

        // ---- full + pop + rejected push in the same cycle
        port_busy = 1;
        for (int i = 8; i <= 11; i++) begin
            issue_v = 1; issue_rd = 5'(i); tick();
        end
        idle();
        for (int i = 8; i <= 11; i++) begin
            ret_v = 1; ret_rd = 5'(i); ret_data = 32'h200 + i; tick();
        end
        idle();
        port_busy = 0; ret_v = 1; ret_rd = 12; ret_data = 32'hBAD; #1;
        chk("t3_ready_full", ret_ready, 0);
        chk("t3_pop_waddr", waddr, 8);
        tick(); idle(); port_busy = 1; #1;
        chk("t3_full_after", q_full, 0);
        chk("t3_ready_after", ret_ready, 1);
        port_busy = 0; #1;
        for (int i = 9; i <= 11; i++) begin
            chk("t3_drain_waddr", waddr, i);
            chk("t3_drain_wd", wd, 32'h200 + i);
            tick(); #1;
        end
        chk("t3_dropped_empty", q_empty, 1);

        // ---- set wins over cancel on the same register
        raddr1 = 7;
        issue_v = 1; issue_rd = 7; tick(); idle(); #1;
        chk("t4_pending", rs1_busy, 1);
        issue_v = 1; issue_rd = 7; cancel_v = 1; cancel_rd = 7;
        tick(); idle(); #1;
        chk("t4_set_wins", rs1_busy, 1);
        cancel_v = 1; cancel_rd = 7; #1;
        chk("t4_cancel_same_cycle", rs1_busy, 1);
        tick(); idle(); #1;
        chk("t4_cancelled", rs1_busy, 0);

        // ---- return to x0 is swallowed
        ret_v = 1; ret_rd = 0; ret_data = 32'h1234; #1;
        chk("t5_ready", ret_ready, 1);
        tick(); idle(); #1;
        chk("t5_no_wen", wen, 0);
        chk("t5_empty", q_empty, 1);

        // ---- reset mid-operation
        port_busy = 1; raddr0 = 13; raddr1 = 14;
        issue_v = 1; issue_rd = 13; tick();
        issue_v = 1; issue_rd = 14; tick(); idle();
        ret_v = 1; ret_rd = 13; ret_data = 32'hAA; tick();
        ret_v = 1; ret_rd = 14; ret_data = 32'hBB; tick(); idle(); #1;
        chk("t6_not_empty", q_empty, 0);
        chk("t6_busy0", rs0_busy, 1);
        rst_l = 0; port_busy = 0; #1;
        chk("t6_async_empty", q_empty, 1);
        chk("t6_async_wen", wen, 0);
        chk("t6_async_busy0", rs0_busy, 0);
        chk("t6_async_busy1", rs1_busy, 0);
        tick();
        rst_l = 1;
        tick(); #1;
        chk("t6_post_empty", q_empty, 1);
        chk("t6_post_wen", wen, 0);
        chk("t6_post_waddr", waddr, 0);
        chk("t6_post_busy0", rs0_busy, 0);
        chk("t6_post_busy1", rs1_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_el2_dec_gpr_wb_queue
